multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the non-pipelined core: fetches one instruction at a time over an instruction-memory handshake and holds the PC and instruction register (IR).
- Decodes RV32I R-type, I-type ALU, LW, SW, B-type and ECALL, and drives every datapath control input one state at a time.
- Sits between the instruction memory and the datapath; consumes the datapath's branch flags and alu_out.

---
 rtl/multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the non-pipelined RV32I core.
// Fetches one instruction at a time over a valid-qualified instruction
// memory port, holds PC/IR/instret, and sequences the datapath controls
// through FETCH, DECODE, EXEC, MEM and WB. ECALL parks the core in HALT;
// illegal opcodes, misaligned taken branches and fetch timeouts park it
// in TRAP. Only reset leaves either terminal state.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  read_reg_r1,
  output logic [4:0]  read_reg_r2,
  output logic [4:0]  reg_write_dest,
  output logic [11:0] read_imm_12,
  output logic [1:0]  imm_sel,
  output logic [3:0]  alu_select,
  output logic        asel,
  output logic        bsel,
  output logic        brun_en,
  output logic        reg_write_en,
  output logic        dm_write_en,
  output logic        wbsel,
  output logic [31:0] pc,
  input  logic        breq_flag,
  input  logic        brlt_flag,
  input  logic        bge_flag,
  input  logic [31:0] alu_out,
  output logic [31:0] instret,
  output logic        halted,
  output logic        trap
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Last wait count before the fetch is declared dead.
  localparam logic [3:0]  TMO_LAST  = 4'(IMEM_TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] instret_reg, instret_next;
  logic        halted_reg, halted_next;
  logic        trap_reg, trap_next;
  logic [3:0]  tmo_reg, tmo_next;
  // Low for the first cycle after reset release so the fetch request
  // only appears from the first clock edge onward.
  logic        run_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_r, is_i, is_lw, is_sw, is_b;
  logic       branch_taken;
  logic       retire;

  assign opcode    = ir_reg[6:0];
  assign funct3    = ir_reg[14:12];
  assign funct7_b5 = ir_reg[30];

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_lw = (opcode == OP_LW);
  assign is_sw = (opcode == OP_SW);
  assign is_b  = (opcode == OP_B);

  // ALU operation for register and immediate arithmetic; immediates never
  // select SUB, but SRAI still uses the funct7[5] alternate bit.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt,
                                        input logic allow_sub);
    logic [3:0] fn;
    case (f3)
      3'b000:  fn = (alt && allow_sub) ? 4'd1 : 4'd0;
      3'b001:  fn = 4'd2;
      3'b010:  fn = 4'd3;
      3'b011:  fn = 4'd4;
      3'b100:  fn = 4'd5;
      3'b101:  fn = alt ? 4'd7 : 4'd6;
      3'b110:  fn = 4'd8;
      default: fn = 4'd9;
    endcase
    return fn;
  endfunction

  // Register fields come straight from IR.
  assign read_reg_r1    = ir_reg[19:15];
  assign read_reg_r2    = ir_reg[24:20];
  assign reg_write_dest = ir_reg[11:7];

  // Datapath control decode, held stable by IR for the whole instruction.
  always_comb begin
    read_imm_12 = ir_reg[31:20];
    imm_sel     = 2'd0;
    alu_select  = 4'd0;
    asel        = 1'b0;
    bsel        = 1'b0;
    brun_en     = 1'b0;
    wbsel       = 1'b0;
    if (is_r) begin
      alu_select = alu_fn(funct3, funct7_b5, 1'b1);
    end else if (is_i) begin
      alu_select = alu_fn(funct3, funct7_b5, 1'b0);
      bsel       = 1'b1;
    end else if (is_lw) begin
      bsel  = 1'b1;
      wbsel = 1'b1;
    end else if (is_sw) begin
      read_imm_12 = {ir_reg[31:25], ir_reg[11:7]};
      imm_sel     = 2'd1;
      bsel        = 1'b1;
    end else if (is_b) begin
      read_imm_12 = {ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8]};
      imm_sel     = 2'd2;
      asel        = 1'b1;
      bsel        = 1'b1;
      brun_en     = funct3[1];
    end
  end

  // Branch condition from the datapath comparator flags.
  always_comb begin
    case (funct3)
      3'b000:        branch_taken = breq_flag;
      3'b001:        branch_taken = ~breq_flag;
      3'b100, 3'b110: branch_taken = brlt_flag;
      3'b101, 3'b111: branch_taken = bge_flag;
      default:       branch_taken = 1'b0;
    endcase
  end

  assign imem_req     = run_reg && (state_reg == S_FETCH);
  assign imem_addr    = pc_reg;
  assign pc           = pc_reg;
  assign instret      = instret_reg;
  assign halted       = halted_reg;
  assign trap         = trap_reg;
  assign reg_write_en = (state_reg == S_WB);
  assign dm_write_en  = (state_reg == S_MEM) && is_sw;

  // Sequencer: walks each instruction class through its states and
  // retires it on its last state.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    instret_next = instret_reg;
    halted_next  = halted_reg;
    trap_next    = trap_reg;
    tmo_next     = tmo_reg;
    retire       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (run_reg) begin
          if (imem_valid) begin
            ir_next    = imem_rdata;
            tmo_next   = 4'd0;
            state_next = S_DECODE;
          end else if (tmo_reg == TMO_LAST) begin
            state_next = S_TRAP;
            trap_next  = 1'b1;
          end else begin
            tmo_next = tmo_reg + 4'd1;
          end
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_lw || is_sw || is_b) begin
          state_next = S_EXEC;
        end else if (opcode == OP_ECALL) begin
          state_next  = S_HALT;
          halted_next = 1'b1;
        end else begin
          state_next = S_TRAP;
          trap_next  = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r || is_i) begin
          state_next = S_WB;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else if (is_b) begin
          if (branch_taken && (alu_out[1:0] != 2'b00)) begin
            state_next = S_TRAP;
            trap_next  = 1'b1;
          end else begin
            retire = 1'b1;
          end
        end else begin
          state_next = S_TRAP;
          trap_next  = 1'b1;
        end
      end
      S_MEM: begin
        if (is_lw) state_next = S_WB;
        else       retire     = 1'b1;
      end
      S_WB:    retire = 1'b1;
      S_HALT:  state_next = S_HALT;
      S_TRAP:  state_next = S_TRAP;
      default: begin
        state_next = S_TRAP;
        trap_next  = 1'b1;
      end
    endcase
    if (retire) begin
      pc_next      = (is_b && branch_taken) ? alu_out : pc_reg + 32'd4;
      instret_next = instret_reg + 32'd1;
      state_next   = S_FETCH;
    end
  end

  // State registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= NOP_INSTR;
      instret_reg <= 32'd0;
      halted_reg  <= 1'b0;
      trap_reg    <= 1'b0;
      tmo_reg     <= 4'd0;
      run_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      instret_reg <= instret_next;
      halted_reg  <= halted_next;
      trap_reg    <= trap_next;
      tmo_reg     <= tmo_next;
      run_reg     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction behavioural model (queue of
// remaining steps per instruction) checked against the DUT every cycle,
// plus directed programs with hand-computed final values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  read_reg_r1, read_reg_r2, reg_write_dest;
  logic [11:0] read_imm_12;
  logic [1:0]  imm_sel;
  logic [3:0]  alu_select;
  logic        asel, bsel, brun_en, reg_write_en, dm_write_en, wbsel;
  logic [31:0] pc;
  logic        breq_flag, brlt_flag, bge_flag;
  logic [31:0] alu_out;
  logic [31:0] instret;
  logic        halted, trap;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .read_reg_r1(read_reg_r1), .read_reg_r2(read_reg_r2),
    .reg_write_dest(reg_write_dest), .read_imm_12(read_imm_12),
    .imm_sel(imm_sel), .alu_select(alu_select), .asel(asel), .bsel(bsel),
    .brun_en(brun_en), .reg_write_en(reg_write_en), .dm_write_en(dm_write_en),
    .wbsel(wbsel), .pc(pc), .breq_flag(breq_flag), .brlt_flag(brlt_flag),
    .bge_flag(bge_flag), .alu_out(alu_out), .instret(instret),
    .halted(halted), .trap(trap)
  );

  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic [1:0]  imm_sel;
    logic [3:0]  alu;
    logic        asel;
    logic        bsel;
    logic        brun;
    logic        wbsel;
  } ctrl_t;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_B = 4, C_EC = 5, C_BAD = 6;
  localparam int S_D = 1, S_E = 2, S_M = 3, S_W = 4;

  int tests = 0;
  int fails = 0;
  int alu_base [8];
  logic [31:0] mem [64];

  // behavioural model
  bit          m_started;
  logic [31:0] m_pc, m_ir, m_instret;
  bit          m_halted, m_trap;
  int          steps [$];
  int          m_wait;

  // stimulus knobs
  int          valid_pct;
  bit          rand_dp;
  logic        d_breq, d_brlt, d_bge;
  logic [31:0] d_alu;
  int          rst_cycles;

  // tallies of DUT activity for directed checks
  int          n_rwe, n_dwe, n_req;
  logic [3:0]  wb_alu;
  logic        wb_wbsel;
  logic        seen_brun;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int cls(input logic [31:0] ir);
    case (ir[6:0])
      7'h33:   return C_R;
      7'h13:   return C_I;
      7'h03:   return C_LW;
      7'h23:   return C_SW;
      7'h63:   return C_B;
      7'h73:   return C_EC;
      default: return C_BAD;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] f3, input logic eq, input logic lt,
                               input logic ge);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return ge;
      default:    return 1'b0;
    endcase
  endfunction

  // Expected controls from the instruction word, using immediate values.
  function automatic ctrl_t exp_ctrl(input logic [31:0] ir);
    ctrl_t e;
    int c;
    logic [12:0] bimm;
    logic [2:0] f3;
    c = cls(ir);
    f3 = ir[14:12];
    bimm = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    e = '0;
    e.r1 = ir[19:15];
    e.r2 = ir[24:20];
    e.rd = ir[11:7];
    e.imm12 = ir[31:20];
    if (c == C_R) begin
      e.alu = 4'(alu_base[f3] + (((f3 == 3'd0 || f3 == 3'd5) && ir[30]) ? 1 : 0));
    end else if (c == C_I) begin
      e.alu = 4'(alu_base[f3] + ((f3 == 3'd5 && ir[30]) ? 1 : 0));
      e.bsel = 1'b1;
    end else if (c == C_LW) begin
      e.bsel = 1'b1;
      e.wbsel = 1'b1;
    end else if (c == C_SW) begin
      e.imm12 = {ir[31:25], ir[11:7]};
      e.imm_sel = 2'd1;
      e.bsel = 1'b1;
    end else if (c == C_B) begin
      e.imm12 = bimm[12:1];
      e.imm_sel = 2'd2;
      e.asel = 1'b1;
      e.bsel = 1'b1;
      e.brun = f3[1];
    end
    return e;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_pc = 32'h0;
    m_ir = 32'h0000_0013;
    m_instret = 32'h0;
    m_halted = 0;
    m_trap = 0;
    steps.delete();
    m_wait = 0;
  endtask

  function automatic bit in_fetch();
    return steps.size() == 0 && !m_halted && !m_trap;
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    int s;
    int c;
    bit tk;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (m_halted || m_trap) return;
    if (steps.size() == 0) begin
      if (imem_valid) begin
        m_ir = imem_rdata;
        m_wait = 0;
        steps.push_back(S_D);
        case (cls(m_ir))
          C_R, C_I: begin steps.push_back(S_E); steps.push_back(S_W); end
          C_LW: begin steps.push_back(S_E); steps.push_back(S_M); steps.push_back(S_W); end
          C_SW: begin steps.push_back(S_E); steps.push_back(S_M); end
          C_B:  steps.push_back(S_E);
          default: ;
        endcase
      end else begin
        m_wait++;
        if (m_wait == 15) m_trap = 1;
      end
      return;
    end
    s = steps.pop_front();
    c = cls(m_ir);
    tk = (c == C_B) && taken(m_ir[14:12], breq_flag, brlt_flag, bge_flag);
    if (s == S_D && c == C_EC) begin
      m_halted = 1;
      return;
    end
    if (s == S_D && c == C_BAD) begin
      m_trap = 1;
      return;
    end
    if (s == S_E && tk && alu_out[1:0] != 2'b00) begin
      m_trap = 1;
      steps.delete();
      return;
    end
    if (steps.size() == 0) begin
      m_pc = tk ? alu_out : m_pc + 32'd4;
      m_instret = m_instret + 32'd1;
    end
  endtask

  task automatic check_cycle();
    ctrl_t e;
    int st;
    e = exp_ctrl(m_ir);
    st = (steps.size() > 0) ? steps[0] : 0;
    chk("imem_req", imem_req, m_started && in_fetch());
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instret", instret, m_instret);
    chk("halted", halted, m_halted);
    chk("trap", trap, m_trap);
    chk("read_reg_r1", read_reg_r1, e.r1);
    chk("read_reg_r2", read_reg_r2, e.r2);
    chk("reg_write_dest", reg_write_dest, e.rd);
    chk("read_imm_12", read_imm_12, e.imm12);
    chk("imm_sel", imm_sel, e.imm_sel);
    chk("alu_select", alu_select, e.alu);
    chk("asel", asel, e.asel);
    chk("bsel", bsel, e.bsel);
    chk("brun_en", brun_en, e.brun);
    chk("wbsel", wbsel, e.wbsel);
    chk("reg_write_en", reg_write_en, st == S_W);
    chk("dm_write_en", dm_write_en, st == S_M && cls(m_ir) == C_SW);
    if (reg_write_en) begin
      n_rwe++;
      wb_alu = alu_select;
      wb_wbsel = wbsel;
    end
    if (dm_write_en) n_dwe++;
    if (imem_req) n_req++;
    if (st == S_E && m_ir[6:0] == 7'h63 && m_ir[14:12] == 3'b110) seen_brun = brun_en;
  endtask

  task automatic drive_inputs();
    int r;
    if (rst_cycles > 0) begin
      rst_n = 1'b0;
      rst_cycles--;
    end else begin
      rst_n = 1'b1;
    end
    if (in_fetch()) begin
      imem_valid = ($urandom_range(0, 99) < valid_pct);
      imem_rdata = imem_valid ? mem[m_pc[7:2]] : $urandom;
    end else begin
      imem_valid = rand_dp ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
    if (rand_dp) begin
      breq_flag = 1'($urandom_range(0, 1));
      brlt_flag = 1'($urandom_range(0, 1));
      bge_flag  = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      alu_out = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (r == 0) alu_out[1:0] = 2'($urandom_range(1, 3));
    end else begin
      breq_flag = d_breq;
      brlt_flag = d_brlt;
      bge_flag  = d_bge;
      alu_out   = d_alu;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    drive_inputs();
    if (!rst_n) model_reset();
    else model_step();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    rst_cycles = 2;
    n_rwe = 0;
    n_dwe = 0;
    n_req = 0;
    wb_alu = 4'hF;
    wb_wbsel = 1'b0;
    seen_brun = 1'b0;
  endtask

  task automatic directed_setup(input logic [31:0] fill);
    for (int i = 0; i < 64; i++) mem[i] = fill;
    valid_pct = 100;
    rand_dp = 0;
    d_breq = 0;
    d_brlt = 0;
    d_bge = 0;
    d_alu = 32'h0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [31:0] w;
    logic [2:0] bf3 [6];
    logic [6:0] bad [4];
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    bad = '{7'h37, 7'h6F, 7'h00, 7'h7F};
    k = $urandom_range(0, 99);
    w = $urandom;
    if (k < 20) begin
      w[31:25] = {1'b0, w[30], 5'b0};
      w[6:0] = 7'h33;
    end else if (k < 40) begin
      w[6:0] = 7'h13;
    end else if (k < 55) begin
      w[14:12] = 3'b010;
      w[6:0] = 7'h03;
    end else if (k < 70) begin
      w[14:12] = 3'b010;
      w[6:0] = 7'h23;
    end else if (k < 90) begin
      w[14:12] = bf3[$urandom_range(0, 5)];
      w[6:0] = 7'h63;
    end else if (k < 95) begin
      w = 32'h0000_0073;
    end else begin
      w[6:0] = bad[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    alu_base = '{0, 2, 3, 4, 5, 6, 8, 9};
    rst_n = 1'b1;
    imem_valid = 0;
    imem_rdata = 0;
    breq_flag = 0;
    brlt_flag = 0;
    bge_flag = 0;
    alu_out = 0;
    rst_cycles = 0;
    directed_setup(32'h0000_0073);
    #1;
    apply_reset();
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_req", imem_req, 1'b0);
    chk("reset_instret", instret, 32'h0);

    // ADD x3,x1,x2 then ECALL
    mem[0] = 32'h0020_81B3;
    run(14);
    chk("add_pc", pc, 32'd4);
    chk("add_instret", instret, 32'd1);
    chk("add_wr_pulses", n_rwe, 1);
    chk("add_alu_sel", wb_alu, 4'd0);
    chk("ecall_halted", halted, 1'b1);
    run(5);
    chk("halt_req_count", n_req, 2);

    // LW x5,8(x0); SW x5,12(x0); ECALL
    directed_setup(32'h0000_0073);
    apply_reset();
    mem[0] = 32'h0080_2283;
    mem[1] = 32'h0050_2623;
    run(22);
    chk("lwsw_pc", pc, 32'd8);
    chk("lwsw_instret", instret, 32'd2);
    chk("lwsw_wr_pulses", n_rwe, 1);
    chk("lwsw_dm_pulses", n_dwe, 1);
    chk("lw_wbsel", wb_wbsel, 1'b1);

    // BEQ +16 taken, BNE not taken, BLTU not taken, ECALL
    directed_setup(32'h0000_0073);
    apply_reset();
    mem[0] = 32'h0000_0863;
    mem[4] = 32'h0000_1463;
    mem[5] = 32'h0000_6463;
    d_breq = 1;
    d_bge = 1;
    d_alu = 32'd16;
    run(25);
    chk("br_pc", pc, 32'd24);
    chk("br_instret", instret, 32'd3);
    chk("bltu_brun", seen_brun, 1'b1);

    // fetch timeout
    directed_setup(32'h0000_0073);
    valid_pct = 0;
    apply_reset();
    run(22);
    chk("tmo_trap", trap, 1'b1);
    chk("tmo_req_count", n_req, 15);
    chk("tmo_req_low", imem_req, 1'b0);
    chk("tmo_pc", pc, 32'h0);

    // illegal opcode
    directed_setup(32'hFFFF_FFFF);
    apply_reset();
    run(10);
    chk("ill_trap", trap, 1'b1);
    chk("ill_pc", pc, 32'h0);
    chk("ill_instret", instret, 32'h0);

    // asynchronous reset in the middle of EXEC of the third ADD
    directed_setup(32'h0020_81B3);
    apply_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle();
      if (m_instret == 32'd2 && steps.size() > 0 && steps[0] == S_E) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL mid_exec_wait: EXEC of third instruction not reached in 60 cycles");
    end else begin
      @(posedge clk);
      #1;
      chk("pre_reset_instret", instret, 32'd2);
      apply_reset();
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_instret", instret, 32'h0);
      chk("arst_req", imem_req, 1'b0);
      chk("arst_rwe", reg_write_en, 1'b0);
      chk("arst_dwe", dm_write_en, 1'b0);
      chk("arst_rd", reg_write_dest, 5'd0);
      chk("arst_bsel", bsel, 1'b1);
      chk("arst_alu", alu_select, 4'd0);
      run(4);
    end

    // randomized programs
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = rand_instr();
      valid_pct = $urandom_range(40, 100);
      rand_dp = 1;
      apply_reset();
      for (int c = 0; c < 300 && !(m_halted || m_trap); c++) cycle();
      run(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
